// File: rtl/ex_issue_ctrl.sv
// Issue sequencer for the st1 execute stage: decodes one instruction at a time,
// reads operands, waits for the result and writes it back. Optional RETIRE_CNT_EN adds retire_count.
module ex_issue_ctrl #(
    parameter int unsigned NREGS   = 8,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TMR_W   = 4
`ifdef RETIRE_CNT_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic              enable_ex,
    output logic [31:0]       src1,
    output logic [31:0]       src2,
    output logic [31:0]       imm,
    output logic [6:0]        control_in,
    input  logic              result_valid,
    input  logic [31:0]       result,
    output logic              busy,
`ifdef RETIRE_CNT_EN
    output logic [CNT_W-1:0]  retire_count,
`endif
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        rd_q, rd_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              timeout_err_q, timeout_err_d;
    logic              enable_ex_q, enable_ex_d;
    logic [31:0]       src1_q, src1_d;
    logic [31:0]       src2_q, src2_d;
    logic [31:0]       imm_q, imm_d;
    logic [6:0]        ctrl_q, ctrl_d;
    logic [31:0]       regs_q [NREGS];
    logic [31:0]       regs_d [NREGS];
    logic              retire;

    logic [6:0]        f_ctrl;
    logic [2:0]        f_rd, f_rs1, f_rs2;
    logic [15:0]       f_imm16;

    assign f_ctrl  = instr[31:25];
    assign f_rd    = instr[24:22];
    assign f_rs1   = instr[21:19];
    assign f_rs2   = instr[18:16];
    assign f_imm16 = instr[15:0];

    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        enable_ex_d   = 1'b0;
        src1_d        = src1_q;
        src2_d        = src2_q;
        imm_d         = imm_q;
        ctrl_d        = ctrl_q;
        regs_d        = regs_q;
        retire        = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    // Operands are captured on the handshake edge so they are valid
                    // together with the enable_ex strobe in the ISSUE cycle.
                    enable_ex_d = 1'b1;
                    src1_d      = (f_rs1 == 3'd0) ? '0 : regs_q[f_rs1];
                    src2_d      = (f_rs2 == 3'd0) ? '0 : regs_q[f_rs2];
                    imm_d       = {{16{f_imm16[15]}}, f_imm16};
                    ctrl_d      = f_ctrl;
                    rd_d        = f_rd;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // ctrl[5] set means store (01) or NOP (11): nothing to wait for.
                if (ctrl_q[5]) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = '0;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (result_valid) begin
                    if (rd_q != 3'd0) begin
                        regs_d[rd_q] = result;
                    end
                    retire  = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rd_q          <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            enable_ex_q   <= 1'b0;
            src1_q        <= '0;
            src2_q        <= '0;
            imm_q         <= '0;
            ctrl_q        <= '0;
            regs_q        <= '{default: '0};
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            enable_ex_q   <= enable_ex_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            imm_q         <= imm_d;
            ctrl_q        <= ctrl_d;
            regs_q        <= regs_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_count_q, retire_count_d;

    always_comb begin
        retire_count_d = retire_count_q;
        if (retire) begin
            retire_count_d = retire_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign enable_ex   = enable_ex_q;
    assign src1        = src1_q;
    assign src2        = src2_q;
    assign imm         = imm_q;
    assign control_in  = ctrl_q;
    assign timeout_err = timeout_err_q;

endmodule
